lstm_top: RTL and testbench
===========================

LSTM_TOP -- requirements
Module: lstm_top

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, signed sample width; 8 is the only supported value.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one LSTM step; sampled on rising clk.
REQ-005 x  input  signed [DATA_WIDTH-1:0] x[0:3]  input vector x_t.
REQ-006 y_in  input  signed [DATA_WIDTH-1:0] y_in[0:3]  previous hidden state h_(t-1).
REQ-007 finished  output  1  one-cycle pulse when y_out is updated.
REQ-008 y_out  output  signed [DATA_WIDTH-1:0] y_out[0:3]  new hidden state h_t, held until the next update.

Function
REQ-009 Number format: all data, weights and biases are signed Q1.6 (1.0 = 64, range -128..127).
REQ-010 Operand vector: v[0..3] = x[0..3] and v[4..7] = y_in[0..3].
- Both are captured into internal registers on the edge where start=1 and the FSM is IDLE.
- Later input changes do not affect the current step.
REQ-011 Gate order is i, f, g, o (index 0..3).
- Pre-activation z[g][j] = sat8((sum over k=0..7 of W[g][j][k]*v[k] + (B[g][j]<<6)) >>> 6).
- Products are 16-bit, the accumulator is at least 20-bit signed, >>> is arithmetic (floor).
- sat8 clamps to -128..127.
REQ-012 Hard sigmoid, for i, f, o: clamp((z>>>2)+32, 0, 64). Hard tanh, for g: clamp(z, -64, 64).
REQ-013 Cell update: c_new[j] = sat8((f*c[j] + i*g) >>> 6).
- c[j] is an internal 8-bit cell-state register that persists between steps.
REQ-014 Output: h[j] = sat8((o * hard_tanh(c_new[j])) >>> 6); y_out[j] <= h[j].
REQ-015 FSM states and transitions:
- IDLE -> MAC on start.
- MAC lasts 8 cycles, k = 0..7; the 16 gate/neuron accumulators run in parallel, one term each cycle.
- MAC -> ACT (1 cycle) -> UPD (1 cycle) -> IDLE.
REQ-016 UPD writes c and y_out, and asserts finished registered, high for exactly the next cycle.
- Latency: finished is high 10 cycles after the edge on which start was accepted.
REQ-017 start while not IDLE is ignored, with no queuing.
- start accepted in IDLE while finished is high begins a new step normally.
REQ-018 start held high across a completed step starts a new step on the first IDLE edge.
REQ-019 Back-to-back steps: the caller feeds y_out back as y_in; the cell state is never supplied externally.

Reset
REQ-020 While rst_n=0, the following are cleared to 0: y_out, finished, c, the accumulators and the captured operands; the FSM is forced to IDLE.
REQ-021 Reset asserted mid-step aborts the step: no finished pulse, and y_out and c read 0 afterwards.

Structure
REQ-022 Shared package lstm_pkg holds the following:
- Q-format constants (FRAC=6, ONE=64).
- Gate index enum (I, F, G, O) and FSM state enum.
- Weight ROM W[4][4][8] and bias B[4][4], all Q1.6.
- Default contents: every W = 8 (0.125), every B = 0.
REQ-023 One sub-module, lstm_act: combinational hard sigmoid / hard tanh selected by a mode bit, instantiated per gate lane.

Verification
REQ-024 Reset, then x = all 0, y_in = all 0, start -> finished 10 cycles later; y_out = {0,0,0,0}.
REQ-025 Reset, then x = {0x25,0x35,0xF5,0xEB}, y_in = 0, start -> z=7, gates i=f=o=33, g=7, c=3; y_out = {1,1,1,1}.
REQ-026 Reset, then x = all 0x7F, y_in = all 0x7F -> z=127, gate=63, g=64, c=63; y_out = {62,62,62,62}.
REQ-027 Reset, then x = all 0x80, y_in = all 0x80 -> z=-128, gate=0, g=-64; c and y_out = 0.
REQ-028 Four chained steps with y_in <= y_out on finished and start the following cycle:
- Exactly four finished pulses, each 1 cycle wide, spaced 11 cycles apart.
- Extra start pulses during MAC are ignored.
REQ-029 rst_n low during MAC cycle 4 -> no finished pulse; y_out = 0; the next start completes normally.

Source files
------------

// File: rtl/lstm_pkg.sv
// lstm_pkg: Q1.6 constants, gate/state enums, weight and bias ROM
// and small fixed-point helpers shared by the LSTM cell.
package lstm_pkg;

  localparam int FRAC = 6;
  localparam int NG   = 4;
  localparam int NN   = 4;
  localparam int NK   = 8;

  typedef logic signed [7:0]  q_t;
  typedef logic signed [19:0] acc_t;

  localparam q_t ONE  = 8'sd64;
  localparam q_t HALF = 8'sd32;

  typedef enum logic [1:0] {
    G_I,
    G_F,
    G_G,
    G_O
  } gate_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ACT,
    S_UPD
  } state_e;

  localparam q_t W [NG][NN][NK] = '{default: 8'sd8};
  localparam q_t B [NG][NN]     = '{default: 8'sd0};

  function automatic q_t sat8(input acc_t v);
    if (v > 20'sd127) return 8'sd127;
    if (v < -20'sd128) return -8'sd128;
    return v[7:0];
  endfunction

  // Sign-extend first so the 20-bit product is exact.
  function automatic acc_t mul8(input q_t a, input q_t b);
    acc_t ae;
    acc_t be;
    ae = {{12{a[7]}}, a};
    be = {{12{b[7]}}, b};
    return ae * be;
  endfunction

endpackage

// File: rtl/lstm_act.sv
// lstm_act: hard sigmoid (sig_i=1) or hard tanh (sig_i=0)
// on one Q1.6 value.
module lstm_act
  import lstm_pkg::*;
(
  input  logic sig_i,
  input  q_t   z_i,
  output q_t   a_o
);

  q_t s;

  always_comb begin
    s = (z_i >>> 2) + HALF;
    if (sig_i) begin
      a_o = s;
      if (s < 8'sd0) a_o = 8'sd0;
      else if (s > ONE) a_o = ONE;
    end else begin
      a_o = z_i;
      if (z_i > ONE) a_o = ONE;
      else if (z_i < -ONE) a_o = -ONE;
    end
  end

endmodule

// File: rtl/lstm_top.sv
// lstm_top: one 4-neuron LSTM step; 8-cycle parallel MAC,
// then activation and cell/hidden update.
module lstm_top
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] x     [0:3],
  input  logic signed [DATA_WIDTH-1:0] y_in  [0:3],
  output logic                         finished,
  output logic signed [DATA_WIDTH-1:0] y_out [0:3]
);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic       fin_q, fin_d;

  q_t   v_q    [NK];
  q_t   v_d    [NK];
  acc_t acc_q  [NG][NN];
  acc_t acc_d  [NG][NN];
  q_t   gate_q [NG][NN];
  q_t   gate_d [NG][NN];
  q_t   c_q    [NN];
  q_t   c_d    [NN];
  q_t   y_q    [NN];
  q_t   y_d    [NN];

  q_t z      [NG][NN];
  q_t act    [NG][NN];
  q_t c_new  [NN];
  q_t c_tanh [NN];
  q_t h      [NN];

  always_comb begin
    for (int g = 0; g < NG; g++)
      for (int j = 0; j < NN; j++)
        z[g][j] = sat8(acc_q[g][j] >>> FRAC);
  end

  for (genvar g = 0; g < NG; g++) begin : g_gate
    for (genvar j = 0; j < NN; j++) begin : g_lane
      lstm_act u_act (
        .sig_i (g != int'(G_G)),
        .z_i   (z[g][j]),
        .a_o   (act[g][j])
      );
    end
  end

  always_comb begin
    for (int j = 0; j < NN; j++)
      c_new[j] = sat8((mul8(gate_q[G_F][j], c_q[j]) +
                       mul8(gate_q[G_I][j], gate_q[G_G][j])) >>> FRAC);
  end

  for (genvar j = 0; j < NN; j++) begin : g_cell
    lstm_act u_tanh (
      .sig_i (1'b0),
      .z_i   (c_new[j]),
      .a_o   (c_tanh[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NN; j++)
      h[j] = sat8(mul8(gate_q[G_O][j], c_tanh[j]) >>> FRAC);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    fin_d   = 1'b0;
    v_d     = v_q;
    acc_d   = acc_q;
    gate_d  = gate_q;
    c_d     = c_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < 4; k++) begin
            v_d[k]   = x[k];
            v_d[k+4] = y_in[k];
          end
          for (int g = 0; g < NG; g++)
            for (int j = 0; j < NN; j++)
              acc_d[g][j] = {{6{B[g][j][7]}}, B[g][j], 6'd0};
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        for (int g = 0; g < NG; g++)
          for (int j = 0; j < NN; j++)
            acc_d[g][j] = acc_q[g][j] + mul8(W[g][j][k_q], v_q[k_q]);
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_ACT;
      end
      S_ACT: begin
        gate_d  = act;
        state_d = S_UPD;
      end
      S_UPD: begin
        c_d     = c_new;
        y_d     = h;
        fin_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      fin_q   <= 1'b0;
      v_q     <= '{default: '0};
      acc_q   <= '{default: '0};
      gate_q  <= '{default: '0};
      c_q     <= '{default: '0};
      y_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fin_q   <= fin_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
      gate_q  <= gate_d;
      c_q     <= c_d;
      y_q     <= y_d;
    end
  end

  assign finished = fin_q;

  for (genvar j = 0; j < NN; j++) begin : g_out
    assign y_out[j] = y_q[j];
  end

endmodule

// File: tb/tb_lstm_top.sv
// tb_lstm_top: directed LSTM steps checked every cycle against a
// step-level arithmetic model, plus hand-computed literals.
module tb_lstm_top;

  localparam int WT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic signed [7:0] x     [0:3];
  logic signed [7:0] y_in  [0:3];
  logic              finished;
  logic signed [7:0] y_out [0:3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fin_seen = 0;

  lstm_top #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x        (x),
    .y_in     (y_in),
    .finished (finished),
    .y_out    (y_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    return v > 127 ? 127 : (v < -128 ? -128 : v);
  endfunction

  function automatic int hsig(input int z);
    int s;
    s = (z >>> 2) + 32;
    return s < 0 ? 0 : (s > 64 ? 64 : s);
  endfunction

  function automatic int htanh(input int z);
    return z > 64 ? 64 : (z < -64 ? -64 : z);
  endfunction

  int m_cnt = 0;
  bit m_fin = 1'b0;
  int m_y [4];
  int m_c [4];
  int p_y [4];
  int p_c [4];

  task automatic model_step();
    int v [8];
    int acc, z, gi, gf, gg, go, cn;
    for (int k = 0; k < 4; k++) begin
      v[k]   = int'(x[k]);
      v[k+4] = int'(y_in[k]);
    end
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) acc += WT * v[k];
      z  = sat(acc >>> 6);
      gi = hsig(z);
      gf = hsig(z);
      go = hsig(z);
      gg = htanh(z);
      cn = sat((gf * m_c[j] + gi * gg) >>> 6);
      p_c[j] = cn;
      p_y[j] = sat((go * htanh(cn)) >>> 6);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_fin <= 1'b0;
      m_y   <= '{default: 0};
      m_c   <= '{default: 0};
    end else begin
      m_fin <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          model_step();
          m_cnt <= 10;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_y   <= p_y;
          m_c   <= p_c;
          m_fin <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (finished) fin_seen <= fin_seen + 1;
    chk("finished", int'(finished), int'(m_fin));
    for (int j = 0; j < 4; j++)
      chk($sformatf("y_out[%0d]", j), int'(y_out[j]), m_y[j]);
  end

  task automatic set_in(input int x0, input int x1, input int x2,
                        input int x3, input int yv);
    x[0] = 8'(x0);
    x[1] = 8'(x1);
    x[2] = 8'(x2);
    x[3] = 8'(x3);
    for (int j = 0; j < 4; j++) y_in[j] = 8'(yv);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(output int lat);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!finished && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic chk_y(input string nm, input int v);
    for (int j = 0; j < 4; j++) chk(nm, int'(y_out[j]), v);
  endtask

  int lat;
  int rec [4];
  int f0;

  initial begin
    set_in(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    do_reset();
    chk("reset_fin", int'(finished), 0);
    chk_y("reset_y", 0);

    // all-zero operands
    set_in(0, 0, 0, 0, 0);
    step(lat);
    chk("lat_zero", lat, 10);
    chk_y("y_zero", 0);

    // small mixed-sign vector: z=7, gates 33, c=3
    do_reset();
    set_in('h25, 'h35, 'hF5, 'hEB, 0);
    step(lat);
    chk("lat_mixed", lat, 10);
    chk_y("y_mixed", 1);

    // positive saturation
    do_reset();
    set_in('h7F, 'h7F, 'h7F, 'h7F, 'h7F);
    step(lat);
    chk("lat_pos", lat, 10);
    chk_y("y_pos", 62);

    // negative saturation
    do_reset();
    set_in('h80, 'h80, 'h80, 'h80, 'h80);
    step(lat);
    chk("lat_neg", lat, 10);
    chk_y("y_neg", 0);

    // four chained steps, y fed back, stray start mid-MAC
    do_reset();
    set_in('h25, 'h35, 'hF5, 'hEB, 0);
    f0 = fin_seen;
    start = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!finished && lat < 30) begin
        @(posedge clk);
        #1 lat++;
        start = (lat == 3);
      end
      chk($sformatf("lat_chain%0d", p), lat, 10);
      rec[p] = cyc;
      if (p > 0) chk($sformatf("spacing%0d", p), rec[p] - rec[p-1], 11);
      if (p == 1) chk_y("y_chain1", 2);
      for (int j = 0; j < 4; j++) y_in[j] = y_out[j];
      start = (p < 3);
    end
    chk_y("y_chain3", 3);
    repeat (3) @(posedge clk);
    #1 chk("chain_pulses", fin_seen - f0, 4);

    // reset during MAC aborts the step
    set_in('h25, 'h35, 'hF5, 'hEB, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    f0 = fin_seen;
    repeat (15) @(posedge clk);
    #1 chk("abort_pulses", fin_seen - f0, 0);
    chk_y("y_abort", 0);
    step(lat);
    chk("lat_after_abort", lat, 10);
    chk_y("y_after_abort", 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
